// File: rtl/prog_ctr_if.sv
// Fetch-stage run-control bundle between the sequencer and its driver.
interface prog_ctr_if #(
  parameter int unsigned D     = 12,
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             stall;
  logic             halt;
  logic             branch_en;
  logic             branch_flag;
  logic [D-1:0]     target;
  logic [D-1:0]     prog_ctr;
  logic             running;
  logic             done;
  logic [CNT_W-1:0] cycle_cnt;

  modport master (
    output start, stall, halt, branch_en, branch_flag, target,
    input  prog_ctr, running, done, cycle_cnt
  );

  modport slave (
    input  start, stall, halt, branch_en, branch_flag, target,
    output prog_ctr, running, done, cycle_cnt
  );
endinterface

// File: rtl/prog_ctr_fsm.sv
// Program counter and run-control sequencer: launches on a falling start,
// steps or branches the PC each RUN cycle, and counts RUN cycles (saturating).
module prog_ctr_fsm #(
  parameter int unsigned D          = 12,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned CNT_W      = 16
) (
  input logic        clk,
  input logic        reset,
  prog_ctr_if.slave  bus
);

  localparam logic [D-1:0]     StartPc = D'(START_ADDR);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [D-1:0]     pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q;
  logic             launch;
  logic [CNT_W-1:0] cnt_inc;

  assign launch  = start_q & ~bus.start;
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state, PC and counter update; first matching RUN rule wins.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        pc_d  = StartPc;
        cnt_d = '0;
        if (launch) state_d = StRun;
      end
      StRun: begin
        if (bus.start) begin
          state_d = StIdle;
          pc_d    = StartPc;
          cnt_d   = '0;
        end else if (bus.halt) begin
          state_d = StDone;
          cnt_d   = cnt_inc;
        end else if (bus.stall) begin
          cnt_d = cnt_inc;
        end else begin
          cnt_d = cnt_inc;
          // Target is two's complement, so a D-bit add wraps correctly both ways.
          if (bus.branch_en && bus.branch_flag) pc_d = pc_q + bus.target;
          else                                  pc_d = pc_q + D'(1);
        end
      end
      StDone: begin
        if (bus.start) begin
          state_d = StIdle;
          pc_d    = StartPc;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, PC, counter and start-history registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= StartPc;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      start_q <= bus.start;
    end
  end

  assign bus.prog_ctr  = pc_q;
  assign bus.cycle_cnt = cnt_q;
  assign bus.running   = (state_q == StRun);
  assign bus.done      = (state_q == StDone);

endmodule

// File: tb/tb_prog_ctr_fsm.sv
// Bench for prog_ctr_fsm: directed vector table, corner sequences, random run.
module tb_prog_ctr_fsm;

  localparam int D      = 12;
  localparam int CNT_W  = 6;
  localparam int PC_MOD = 1 << D;
  localparam int CNT_MX = (1 << CNT_W) - 1;

  logic clk;
  logic reset;

  prog_ctr_if #(.D(D), .CNT_W(CNT_W)) bus ();

  prog_ctr_fsm #(.D(D), .START_ADDR(0), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0 = idle, 1 = run, 2 = done.
  int m_mode, m_pc, m_cnt;
  bit m_prev_start;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int wrap_pc(input int v);
    return ((v % PC_MOD) + PC_MOD) % PC_MOD;
  endfunction

  function automatic int signed_tgt(input int t);
    return (t >= PC_MOD / 2) ? t - PC_MOD : t;
  endfunction

  function automatic int sat_inc(input int c);
    return (c >= CNT_MX) ? CNT_MX : c + 1;
  endfunction

  task automatic model_step();
    bit launch;
    if (reset) begin
      m_mode = 0; m_pc = 0; m_cnt = 0; m_prev_start = 0;
      return;
    end
    launch = m_prev_start && !bus.start;
    if (m_mode == 0) begin
      m_pc = 0; m_cnt = 0;
      if (launch) m_mode = 1;
    end else if (m_mode == 1) begin
      if (bus.start) begin
        m_mode = 0; m_pc = 0; m_cnt = 0;
      end else if (bus.halt) begin
        m_mode = 2; m_cnt = sat_inc(m_cnt);
      end else if (bus.stall) begin
        m_cnt = sat_inc(m_cnt);
      end else begin
        m_cnt = sat_inc(m_cnt);
        if (bus.branch_en && bus.branch_flag)
          m_pc = wrap_pc(m_pc + signed_tgt(int'(bus.target)));
        else
          m_pc = wrap_pc(m_pc + 1);
      end
    end else if (bus.start) begin
      m_mode = 0; m_pc = 0; m_cnt = 0;
    end
    m_prev_start = bus.start;
  endtask

  task automatic drive(input bit rst, input bit st, input bit stl, input bit hlt,
                       input bit ben, input bit bfl, input logic [D-1:0] tgt);
    reset           = rst;
    bus.start       = st;
    bus.stall       = stl;
    bus.halt        = hlt;
    bus.branch_en   = ben;
    bus.branch_flag = bfl;
    bus.target      = tgt;
  endtask

  task automatic step_raw();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic tick(input string name);
    step_raw();
    check({name, " pc"},      int'(bus.prog_ctr),  m_pc);
    check({name, " cnt"},     int'(bus.cycle_cnt), m_cnt);
    check({name, " running"}, int'(bus.running),   int'(m_mode == 1));
    check({name, " done"},    int'(bus.done),      int'(m_mode == 2));
  endtask

  typedef struct {
    bit         rst, st, stl, hlt, ben, bfl;
    logic [D-1:0] tgt;
    int         pc;
    bit         run, dn;
    int         cnt;
  } vec_t;

  function automatic vec_t mk(input bit rst, input bit st, input bit stl, input bit hlt,
                              input bit ben, input bit bfl, input int tgt,
                              input int pc, input bit run, input bit dn, input int cnt);
    vec_t v;
    v.rst = rst; v.st = st; v.stl = stl; v.hlt = hlt; v.ben = ben; v.bfl = bfl;
    v.tgt = D'(tgt); v.pc = pc; v.run = run; v.dn = dn; v.cnt = cnt;
    return v;
  endfunction

  vec_t vecs[21];

  initial begin
    // rst st stl hlt ben bfl tgt -> pc run done cnt
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 'h000, 'h000, 0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 0, 0, 'h000, 'h000, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 'h000, 'h000, 1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 'h000, 'h001, 1, 0, 1);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 'h000, 'h002, 1, 0, 2);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 'h000, 'h003, 1, 0, 3);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 'h000, 'h004, 1, 0, 4);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 'h000, 'h005, 1, 0, 5);
    vecs[8]  = mk(0, 0, 0, 0, 1, 1, 'h003, 'h008, 1, 0, 6);
    vecs[9]  = mk(0, 0, 0, 0, 1, 1, 'hFFB, 'h003, 1, 0, 7);
    vecs[10] = mk(0, 0, 0, 0, 1, 1, 'h005, 'h008, 1, 0, 8);
    vecs[11] = mk(0, 0, 0, 0, 1, 0, 'hFFB, 'h009, 1, 0, 9);
    vecs[12] = mk(0, 0, 0, 0, 1, 1, 'hFFF, 'h008, 1, 0, 10);
    vecs[13] = mk(0, 0, 0, 0, 1, 1, 'h014, 'h01C, 1, 0, 11);
    vecs[14] = mk(0, 0, 0, 0, 1, 1, 'h000, 'h01C, 1, 0, 12);
    vecs[15] = mk(0, 0, 0, 0, 1, 1, 'hFE3, 'hFFF, 1, 0, 13);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 'h000, 'h000, 1, 0, 14);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 'h000, 'h001, 1, 0, 15);
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 'h000, 'h002, 1, 0, 16);
    vecs[19] = mk(0, 0, 0, 0, 1, 1, 'hFFB, 'hFFD, 1, 0, 17);
    vecs[20] = mk(0, 1, 0, 0, 0, 0, 'h000, 'h000, 0, 0, 0);

    drive(1, 0, 0, 0, 0, 0, '0);
    m_mode = 0; m_pc = 0; m_cnt = 0; m_prev_start = 0;

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].stl, vecs[i].hlt,
            vecs[i].ben, vecs[i].bfl, vecs[i].tgt);
      step_raw();
      check($sformatf("vec%0d pc", i),      int'(bus.prog_ctr),  vecs[i].pc);
      check($sformatf("vec%0d running", i), int'(bus.running),   int'(vecs[i].run));
      check($sformatf("vec%0d done", i),    int'(bus.done),      int'(vecs[i].dn));
      check($sformatf("vec%0d cnt", i),     int'(bus.cycle_cnt), vecs[i].cnt);
    end

    // Halt together with a taken branch, then DONE ignores everything but start.
    drive(0, 1, 0, 0, 0, 0, '0); tick("h_idle");
    drive(0, 0, 0, 0, 0, 0, '0); tick("h_launch");
    drive(0, 0, 0, 0, 1, 1, 'h010); tick("h_br");
    drive(0, 0, 0, 1, 1, 1, 'h005); tick("h_halt");
    check("halt pc", int'(bus.prog_ctr), 'h010);
    check("halt done", int'(bus.done), 1);
    check("halt cnt", int'(bus.cycle_cnt), 2);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, k[0], k[1], 1, 1, 'h007); tick("h_frozen");
    end
    check("frozen pc", int'(bus.prog_ctr), 'h010);
    check("frozen cnt", int'(bus.cycle_cnt), 2);

    // Restart from DONE, then stall over a taken branch.
    drive(0, 1, 0, 0, 0, 0, '0); tick("s_idle");
    check("done drop", int'(bus.done), 0);
    drive(0, 0, 0, 0, 0, 0, '0); tick("s_launch");
    check("relaunch pc", int'(bus.prog_ctr), 0);
    drive(0, 0, 0, 0, 1, 1, 'h005); tick("s_br");
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 0, 1, 1, 'h040); tick("s_stall");
    end
    check("stall pc", int'(bus.prog_ctr), 'h005);
    check("stall cnt", int'(bus.cycle_cnt), 4);
    drive(0, 0, 0, 0, 0, 0, '0); tick("s_resume");
    check("resume pc", int'(bus.prog_ctr), 'h006);

    // Abort by start, start held high, then reset mid-run.
    drive(0, 0, 0, 0, 1, 1, 'h01A); tick("a_br");
    check("abort pre pc", int'(bus.prog_ctr), 'h020);
    drive(0, 1, 0, 0, 0, 0, '0); tick("a_abort");
    check("abort pc", int'(bus.prog_ctr), 0);
    check("abort cnt", int'(bus.cycle_cnt), 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0, 0, 0, '0); tick("a_hold");
    end
    check("held start running", int'(bus.running), 0);
    drive(0, 0, 0, 0, 0, 0, '0); tick("a_launch");
    drive(0, 0, 0, 0, 0, 0, '0); tick("a_step");
    drive(1, 0, 0, 0, 0, 0, '0); tick("a_reset");
    check("reset pc", int'(bus.prog_ctr), 0);
    check("reset running", int'(bus.running), 0);
    drive(0, 0, 0, 0, 0, 0, '0); tick("a_post_reset");
    check("no launch after reset", int'(bus.running), 0);

    // Counter saturation.
    drive(0, 1, 0, 0, 0, 0, '0); tick("c_idle");
    drive(0, 0, 0, 0, 0, 0, '0); tick("c_launch");
    for (int k = 0; k < 70; k++) tick("c_run");
    check("sat cnt", int'(bus.cycle_cnt), CNT_MX);
    check("sat pc", int'(bus.prog_ctr), 70);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom % 64) == 0, ($urandom % 10) == 0, ($urandom % 6) == 0,
            ($urandom % 20) == 0, ($urandom % 3) == 0, ($urandom % 2) == 0,
            D'($urandom));
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_ctr_fsm.md
Name: prog_ctr_fsm

Overview:
Program counter and run-control sequencer for the core's fetch stage. It sits directly downstream of PC_Controller and consumes that block's D-bit signed `target` offset for relative branches. It drives the instruction-memory address, sequences program start/halt with a start/done handshake to the testbench, and counts executed cycles.

Parameters:
- D, 12: PC width in bits; must match PC_Controller's D.
- START_ADDR, 0: PC value loaded on reset and on every new start.
- CNT_W, 16: width of the cycle counter.

Ports:
- clk, input, 1: single system clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: run request; a program launches on the falling edge of start.
- stall, input, 1: hold the PC this cycle (memory wait).
- halt, input, 1: decoded halt instruction at the current PC.
- branch_en, input, 1: current instruction is a relative branch.
- branch_flag, input, 1: branch condition result from the ALU.
- target, input, D: signed two's-complement PC offset from PC_Controller.
- prog_ctr, output, D: registered instruction address.
- running, output, 1: high while in RUN.
- done, output, 1: high while in DONE.
- cycle_cnt, output, CNT_W: RUN cycles elapsed since launch.

Behaviour:
- Reset (synchronous, highest priority):
  - state is IDLE; prog_ctr=START_ADDR; running=0; done=0; cycle_cnt=0; start_d=0.
  - A reset asserted mid-RUN aborts the program on that edge.
- All outputs are registered; running and done decode directly from state flops.
- start_d is a 1-flop delayed copy of start. Launch condition: start_d=1 and start=0.
- IDLE:
  - prog_ctr is held at START_ADDR and cycle_cnt=0.
  - On launch -> RUN. The first RUN cycle presents START_ADDR.
- RUN: each edge applies the first matching rule, in this order:
  1. start=1: abort -> IDLE; prog_ctr<=START_ADDR; cycle_cnt<=0.
  2. halt=1: -> DONE; prog_ctr holds; cycle_cnt increments for this final cycle.
  3. stall=1: prog_ctr holds; cycle_cnt increments.
  4. branch_en=1 and branch_flag=1: prog_ctr<=prog_ctr+target.
  5. Otherwise: prog_ctr<=prog_ctr+1.
- Rules 4 and 5 both increment cycle_cnt.
- Branch arithmetic is D-bit modulo, with target treated as signed. Examples:
  - 0x003 + 0xFFB = 0xFFE (wraps below zero).
  - target=0 holds the PC (legal self-loop, not an error).
- A branch with branch_en=1 and branch_flag=0 falls through to PC+1.
- Sequential wrap: 2^D-1 +1 -> 0, with no flag raised.
- cycle_cnt saturates at 2^CNT_W-1 and never wraps.
- DONE:
  - prog_ctr and cycle_cnt hold; done=1.
  - start=1 -> IDLE on that edge, so done drops the next cycle and prog_ctr<=START_ADDR, cycle_cnt<=0.
  - A subsequent start fall launches again. halt/stall/branch inputs are ignored.
- Simultaneous events:
  - halt with a branch taken: halt wins, PC does not move.
  - stall with a branch taken: stall wins, and the branch must be re-presented by upstream.
- start held high continuously: the block stays in IDLE.
- Latency: input decisions affect prog_ctr on the next edge (1 cycle).

Test Plan:
1. Reset, then start pulse 1->0 with no branches for 5 cycles -> prog_ctr 0,1,2,3,4; running=1; cycle_cnt=5.
2. At PC=0x008, branch_en=1, branch_flag=1, target=0xFFB -> prog_ctr=0x003. Same with branch_flag=0 -> 0x009. With target=0x014 -> 0x01C.
3. PC=0xFFF with no branch -> 0x000. PC=0x002 with taken branch target=0xFFB -> 0xFFD.
4. halt and a taken branch asserted together at PC=0x010 -> DONE; prog_ctr stays 0x010; done=1, running=0; cycle_cnt frozen; later branch pulses have no effect.
5. stall held 3 cycles at PC=0x005 -> PC stays 0x005 and cycle_cnt advances by 3. A taken branch during the stall is ignored.
6. start=1 mid-RUN at PC=0x020 -> IDLE, prog_ctr=START_ADDR, cycle_cnt=0. Synchronous reset mid-RUN -> same values, done=0. From DONE, start pulse -> relaunch from START_ADDR.
